// File: rtl/dmem_access_unit.sv
// dmem_access_unit
//   Bridges the RV32I MEM stage to a valid/ready data-memory bus. Accepts one
//   load/store at a time, builds the word-aligned bus request (byte strobes,
//   lane-replicated store data), extracts and extends load data, and reports
//   alignment faults without touching the bus.
// Ports
//   clk_i, reset_i              clock, synchronous active-high reset
//   in_valid_i / in_ready_o     MEM-stage request handshake
//   in_addr_i, in_wdata_i       byte address, store data
//   in_wr_i, in_size_i          1=store/0=load; BYTE=0, HALF=1, WORD=2 (3 acts as WORD)
//   in_signed_i                 sign-extend load result
//   dmem_req_*                  bus request channel (valid/ready, addr, we, wstrb, wdata)
//   dmem_resp_*                 bus load response (valid, rdata)
//   out_valid_o                 one-cycle completion pulse
//   out_rdata_o                 extended load data (0 for stores/faults)
//   out_misaligned_o            access faulted on alignment
module dmem_access_unit (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] in_addr_i,
  input  logic [31:0] in_wdata_i,
  input  logic        in_wr_i,
  input  logic [1:0]  in_size_i,
  input  logic        in_signed_i,
  output logic        dmem_req_valid_o,
  input  logic        dmem_req_ready_i,
  output logic [31:0] dmem_req_addr_o,
  output logic        dmem_req_we_o,
  output logic [3:0]  dmem_req_wstrb_o,
  output logic [31:0] dmem_req_wdata_o,
  input  logic        dmem_resp_valid_i,
  input  logic [31:0] dmem_resp_rdata_i,
  output logic        out_valid_o,
  output logic [31:0] out_rdata_o,
  output logic        out_misaligned_o
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_RESP, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, wdata_q;
  logic        wr_q, signed_q;
  logic [1:0]  size_q;
  logic        misaligned_in;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] load_data;

  // Alignment check on the incoming request, before it is latched.
  always_comb begin
    misaligned_in = 1'b0;
    case (in_size_i)
      2'd0:    misaligned_in = 1'b0;
      2'd1:    misaligned_in = in_addr_i[0];
      default: misaligned_in = |in_addr_i[1:0];
    endcase
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (in_valid_i)        state_d = misaligned_in ? S_DONE : S_REQ;
      S_REQ:       if (dmem_req_ready_i)  state_d = wr_q ? S_DONE : S_WAIT_RESP;
      S_WAIT_RESP: if (dmem_resp_valid_i) state_d = S_DONE;
      S_DONE:                             state_d = S_IDLE;
      default:                            state_d = S_IDLE;
    endcase
  end

  // Load lane extraction from the live response word.
  always_comb begin
    byte_lane = '0;
    case (addr_q[1:0])
      2'd0: byte_lane = dmem_resp_rdata_i[7:0];
      2'd1: byte_lane = dmem_resp_rdata_i[15:8];
      2'd2: byte_lane = dmem_resp_rdata_i[23:16];
      2'd3: byte_lane = dmem_resp_rdata_i[31:24];
      default: byte_lane = '0;
    endcase
    half_lane = addr_q[1] ? dmem_resp_rdata_i[31:16] : dmem_resp_rdata_i[15:0];
    load_data = dmem_resp_rdata_i;
    case (size_q)
      2'd0:    load_data = {{24{signed_q & byte_lane[7]}}, byte_lane};
      2'd1:    load_data = {{16{signed_q & half_lane[15]}}, half_lane};
      default: load_data = dmem_resp_rdata_i;
    endcase
  end

  // Request latch and result registers; results hold between completions.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      addr_q           <= '0;
      wdata_q          <= '0;
      wr_q             <= 1'b0;
      size_q           <= '0;
      signed_q         <= 1'b0;
      out_rdata_o      <= '0;
      out_misaligned_o <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (in_valid_i) begin
          addr_q   <= in_addr_i;
          wdata_q  <= in_wdata_i;
          wr_q     <= in_wr_i;
          size_q   <= in_size_i;
          signed_q <= in_signed_i;
          if (misaligned_in) begin
            out_rdata_o      <= '0;
            out_misaligned_o <= 1'b1;
          end
        end
        S_REQ: if (dmem_req_ready_i && wr_q) begin
          out_rdata_o      <= '0;
          out_misaligned_o <= 1'b0;
        end
        S_WAIT_RESP: if (dmem_resp_valid_i) begin
          out_rdata_o      <= load_data;
          out_misaligned_o <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Outputs: bus fields come straight from the latch, so they stay stable in REQ.
  always_comb begin
    in_ready_o       = (state_q == S_IDLE);
    dmem_req_valid_o = (state_q == S_REQ);
    out_valid_o      = (state_q == S_DONE);
    dmem_req_addr_o  = {addr_q[31:2], 2'b00};
    dmem_req_we_o    = wr_q;
    dmem_req_wstrb_o = '0;
    dmem_req_wdata_o = wdata_q;
    case (size_q)
      2'd0: begin
        dmem_req_wstrb_o = 4'b0001 << addr_q[1:0];
        dmem_req_wdata_o = {4{wdata_q[7:0]}};
      end
      2'd1: begin
        dmem_req_wstrb_o = 4'b0011 << addr_q[1:0];
        dmem_req_wdata_o = {2{wdata_q[15:0]}};
      end
      default: dmem_req_wstrb_o = 4'b1111;
    endcase
    if (!wr_q) dmem_req_wstrb_o = '0;
  end

endmodule

// File: tb/tb_dmem_access_unit.sv
// tb_dmem_access_unit
//   Self-checking bench: directed scenarios plus randomized transactions, all
//   checked against an arithmetic reference model of the access rules.
module tb_dmem_access_unit;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        in_valid_i, in_ready_o;
  logic [31:0] in_addr_i, in_wdata_i;
  logic        in_wr_i, in_signed_i;
  logic [1:0]  in_size_i;
  logic        dmem_req_valid_o, dmem_req_ready_i;
  logic [31:0] dmem_req_addr_o, dmem_req_wdata_o;
  logic        dmem_req_we_o;
  logic [3:0]  dmem_req_wstrb_o;
  logic        dmem_resp_valid_i;
  logic [31:0] dmem_resp_rdata_i;
  logic        out_valid_o, out_misaligned_o;
  logic [31:0] out_rdata_o;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  dmem_access_unit dut (
    .clk_i(clk), .reset_i(reset_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_addr_i(in_addr_i), .in_wdata_i(in_wdata_i), .in_wr_i(in_wr_i),
    .in_size_i(in_size_i), .in_signed_i(in_signed_i),
    .dmem_req_valid_o(dmem_req_valid_o), .dmem_req_ready_i(dmem_req_ready_i),
    .dmem_req_addr_o(dmem_req_addr_o), .dmem_req_we_o(dmem_req_we_o),
    .dmem_req_wstrb_o(dmem_req_wstrb_o), .dmem_req_wdata_o(dmem_req_wdata_o),
    .dmem_resp_valid_i(dmem_resp_valid_i), .dmem_resp_rdata_i(dmem_resp_rdata_i),
    .out_valid_o(out_valid_o), .out_rdata_o(out_rdata_o),
    .out_misaligned_o(out_misaligned_o)
  );

  // Advance one clock and sample 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scramble the request inputs while in_valid_i is low: the DUT must use its latch.
  task automatic scramble();
    in_addr_i   = $urandom;
    in_wdata_i  = $urandom;
    in_wr_i     = 1'($urandom_range(0, 1));
    in_size_i   = 2'($urandom_range(0, 3));
    in_signed_i = 1'($urandom_range(0, 1));
  endtask

  // One complete transaction from IDLE, checked against the reference model.
  task automatic do_txn(input logic [31:0] a, input logic [31:0] wd, input logic wr,
                        input logic [1:0] sz, input logic sg, input logic [31:0] rd,
                        input int rdly, input int sdly);
    int          nb;
    int          ofs;
    logic        mis;
    logic [3:0]  e_strb;
    logic [31:0] e_wdata, e_rdata, mask, sh;
    nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    ofs = int'(a % 4);
    mis = (a % nb) != 0;
    e_strb  = wr ? 4'(((1 << nb) - 1) << ofs) : 4'h0;
    e_wdata = (nb == 1) ? {24'h0, wd[7:0]} * 32'h0101_0101 :
              (nb == 2) ? {16'h0, wd[15:0]} * 32'h0001_0001 : wd;
    mask = (nb == 4) ? 32'hFFFF_FFFF : 32'((1 << (8 * nb)) - 1);
    sh   = (rd >> (8 * ofs)) & mask;
    if (sg && nb < 4 && sh[8 * nb - 1]) sh = sh | ~mask;
    e_rdata = (wr || mis) ? 32'h0 : sh;

    vectors++; if (in_ready_o !== 1'b1) begin miscompares++; $display("FAIL idle_ready: got %b want 1", in_ready_o); end
    in_valid_i = 1'b1; in_addr_i = a; in_wdata_i = wd; in_wr_i = wr; in_size_i = sz; in_signed_i = sg;
    dmem_req_ready_i = 1'b0; dmem_resp_valid_i = 1'b0;
    step();
    in_valid_i = 1'b0; scramble();

    if (mis) begin
      vectors++; if (out_valid_o !== 1'b1) begin miscompares++; $display("FAIL mis_valid: got %b want 1", out_valid_o); end
      vectors++; if (out_misaligned_o !== 1'b1) begin miscompares++; $display("FAIL mis_flag: got %b want 1", out_misaligned_o); end
      vectors++; if (out_rdata_o !== 32'h0) begin miscompares++; $display("FAIL mis_rdata: got %h want 0", out_rdata_o); end
      vectors++; if (dmem_req_valid_o !== 1'b0) begin miscompares++; $display("FAIL mis_noreq: got %b want 0", dmem_req_valid_o); end
    end else begin
      for (int k = 0; k <= rdly; k++) begin
        vectors++; if (dmem_req_valid_o !== 1'b1) begin miscompares++; $display("FAIL req_valid: got %b want 1", dmem_req_valid_o); end
        vectors++; if (dmem_req_addr_o !== {a[31:2], 2'b00}) begin miscompares++; $display("FAIL req_addr: got %h want %h", dmem_req_addr_o, {a[31:2], 2'b00}); end
        vectors++; if (dmem_req_we_o !== wr) begin miscompares++; $display("FAIL req_we: got %b want %b", dmem_req_we_o, wr); end
        vectors++; if (dmem_req_wstrb_o !== e_strb) begin miscompares++; $display("FAIL req_wstrb: got %b want %b", dmem_req_wstrb_o, e_strb); end
        if (wr) begin
          vectors++; if (dmem_req_wdata_o !== e_wdata) begin miscompares++; $display("FAIL req_wdata: got %h want %h", dmem_req_wdata_o, e_wdata); end
        end
        vectors++; if (out_valid_o !== 1'b0) begin miscompares++; $display("FAIL req_noout: got %b want 0", out_valid_o); end
        dmem_req_ready_i  = (k == rdly);
        dmem_resp_valid_i = 1'($urandom_range(0, 1));   // must be ignored in REQ
        dmem_resp_rdata_i = $urandom;
        step();
      end
      dmem_req_ready_i = 1'b0;
      if (!wr) begin
        for (int j = 0; j <= sdly; j++) begin
          vectors++; if (out_valid_o !== 1'b0 || dmem_req_valid_o !== 1'b0) begin miscompares++; $display("FAIL wait_idle: got out_valid=%b req_valid=%b want 0 0", out_valid_o, dmem_req_valid_o); end
          dmem_resp_valid_i = (j == sdly);
          dmem_resp_rdata_i = (j == sdly) ? rd : $urandom;
          dmem_req_ready_i  = 1'($urandom_range(0, 1));  // must be ignored outside REQ
          step();
        end
        dmem_resp_valid_i = 1'b0; dmem_req_ready_i = 1'b0;
      end
      vectors++; if (out_valid_o !== 1'b1) begin miscompares++; $display("FAIL done_valid: got %b want 1", out_valid_o); end
      vectors++; if (out_misaligned_o !== 1'b0) begin miscompares++; $display("FAIL done_mis: got %b want 0", out_misaligned_o); end
      vectors++; if (out_rdata_o !== e_rdata) begin miscompares++; $display("FAIL done_rdata: got %h want %h", out_rdata_o, e_rdata); end
    end
    dmem_resp_valid_i = 1'($urandom_range(0, 1));  // stray response in DONE
    dmem_resp_rdata_i = $urandom;
    step();
    dmem_resp_valid_i = 1'b0;
    vectors++; if (out_valid_o !== 1'b0) begin miscompares++; $display("FAIL pulse_len: got %b want 0", out_valid_o); end
    vectors++; if (in_ready_o !== 1'b1) begin miscompares++; $display("FAIL back_idle: got %b want 1", in_ready_o); end
    vectors++; if (out_rdata_o !== e_rdata) begin miscompares++; $display("FAIL rdata_hold: got %h want %h", out_rdata_o, e_rdata); end
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    step(); step();
    reset_i = 1'b0;
    vectors++; if (in_ready_o !== 1'b1) begin miscompares++; $display("FAIL rst_ready: got %b want 1", in_ready_o); end
    vectors++; if (dmem_req_valid_o !== 1'b0) begin miscompares++; $display("FAIL rst_reqv: got %b want 0", dmem_req_valid_o); end
    vectors++; if (out_valid_o !== 1'b0) begin miscompares++; $display("FAIL rst_outv: got %b want 0", out_valid_o); end
    vectors++; if (out_rdata_o !== 32'h0) begin miscompares++; $display("FAIL rst_rdata: got %h want 0", out_rdata_o); end
    vectors++; if (out_misaligned_o !== 1'b0) begin miscompares++; $display("FAIL rst_mis: got %b want 0", out_misaligned_o); end
    vectors++; if (dmem_req_addr_o !== 32'h0 || dmem_req_we_o !== 1'b0) begin miscompares++; $display("FAIL rst_latch: got addr=%h we=%b want 0 0", dmem_req_addr_o, dmem_req_we_o); end
  endtask

  task automatic test_directed();
    do_txn(32'h0000_0103, 32'h0, 1'b0, 2'd0, 1'b1, 32'h80FF_1234, 0, 0);  // LB
    vectors++; if (out_rdata_o !== 32'hFFFF_FF80) begin miscompares++; $display("FAIL lb_signed: got %h want ffffff80", out_rdata_o); end
    do_txn(32'h0000_0202, 32'h0000_ABCD, 1'b1, 2'd1, 1'b0, 32'h0, 3, 0); // SH, ready late
    do_txn(32'h0000_0301, 32'h0, 1'b0, 2'd2, 1'b0, 32'h0, 0, 0);         // LW misaligned
    vectors++; if (out_misaligned_o !== 1'b1) begin miscompares++; $display("FAIL lw_mis_hold: got %b want 1", out_misaligned_o); end
    do_txn(32'h0000_0402, 32'h0, 1'b0, 2'd1, 1'b0, 32'h9876_0000, 1, 2); // LHU
    vectors++; if (out_rdata_o !== 32'h0000_9876) begin miscompares++; $display("FAIL lhu: got %h want 00009876", out_rdata_o); end
    do_txn(32'h0000_0402, 32'h0, 1'b0, 2'd1, 1'b1, 32'h9876_0000, 0, 1); // LH
    vectors++; if (out_rdata_o !== 32'hFFFF_9876) begin miscompares++; $display("FAIL lh: got %h want ffff9876", out_rdata_o); end
    do_txn(32'h0000_0502, 32'h0, 1'b1, 2'd3, 1'b0, 32'h0, 0, 0);         // size 3 faults as WORD
  endtask

  task automatic test_reset_midflight();
    // Reset while REQ is stalled.
    in_valid_i = 1'b1; in_addr_i = 32'h600; in_wr_i = 1'b0; in_size_i = 2'd2; in_signed_i = 1'b0;
    step();
    in_valid_i = 1'b0;
    reset_i = 1'b1; step(); reset_i = 1'b0;
    vectors++; if (dmem_req_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin miscompares++; $display("FAIL rst_req: got req_valid=%b ready=%b want 0 1", dmem_req_valid_o, in_ready_o); end
    dmem_req_ready_i = 1'b1; step(); dmem_req_ready_i = 1'b0;
    vectors++; if (out_valid_o !== 1'b0 || dmem_req_valid_o !== 1'b0) begin miscompares++; $display("FAIL rst_req_late: got out_valid=%b req_valid=%b want 0 0", out_valid_o, dmem_req_valid_o); end
    // Reset while waiting for a load response; the response arrives late.
    in_valid_i = 1'b1; in_addr_i = 32'h700; in_size_i = 2'd2;
    step();
    in_valid_i = 1'b0; dmem_req_ready_i = 1'b1;
    step();
    dmem_req_ready_i = 1'b0; reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    vectors++; if (in_ready_o !== 1'b1) begin miscompares++; $display("FAIL rst_wait_ready: got %b want 1", in_ready_o); end
    dmem_resp_valid_i = 1'b1; dmem_resp_rdata_i = 32'hDEAD_BEEF;
    step();
    dmem_resp_valid_i = 1'b0;
    vectors++; if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin miscompares++; $display("FAIL rst_wait_resp: got out_valid=%b ready=%b want 0 1", out_valid_o, in_ready_o); end
    vectors++; if (out_rdata_o !== 32'h0) begin miscompares++; $display("FAIL rst_wait_rdata: got %h want 0", out_rdata_o); end
    step();
    vectors++; if (out_valid_o !== 1'b0) begin miscompares++; $display("FAIL rst_wait_quiet: got %b want 0", out_valid_o); end
  endtask

  task automatic test_back_to_back();
    // in_valid held high: a request may only be taken in the IDLE cycle after DONE.
    in_valid_i = 1'b1; in_addr_i = 32'h301; in_wr_i = 1'b0; in_size_i = 2'd2; in_signed_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      vectors++; if (out_valid_o !== ((i % 2) == 0)) begin miscompares++; $display("FAIL b2b_valid[%0d]: got %b want %b", i, out_valid_o, (i % 2) == 0); end
      vectors++; if (in_ready_o !== ((i % 2) == 1)) begin miscompares++; $display("FAIL b2b_ready[%0d]: got %b want %b", i, in_ready_o, (i % 2) == 1); end
    end
    in_valid_i = 1'b0;
    step();
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int n = 0; n < 200; n++) begin
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;  // bias toward aligned accesses
      do_txn(a, $urandom, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
    end
  endtask

  initial begin
    reset_i = 1'b1; in_valid_i = 1'b0; dmem_req_ready_i = 1'b0;
    dmem_resp_valid_i = 1'b0; dmem_resp_rdata_i = '0;
    scramble();
    step();
    test_reset();
    test_directed();
    test_reset_midflight();
    test_back_to_back();
    test_random();
    do_txn(32'h0000_0301, 32'h0, 1'b0, 2'd2, 1'b0, 32'h0, 0, 0);
    test_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dmem_access_unit.md
DMEM_ACCESS_UNIT -- requirements
Module: dmem_access_unit

Interface
REQ-001 Parameters: none; all widths fixed by the 32-bit RV32I datapath.
REQ-002 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-003 reset_i  input  1  synchronous, active-high reset.
REQ-004 in_valid_i  input  1  MEM-stage request valid.
REQ-005 in_ready_o  output  1  unit can accept a request this cycle.
REQ-006 in_addr_i  input  32  byte address (alu_out of MEM stage).
REQ-007 in_wdata_i  input  32  store data (regfile_out2 of MEM stage).
REQ-008 in_wr_i  input  1  1 = store, 0 = load.
REQ-009 in_size_i  input  2  mem_access_size_t: BYTE=0, HALF=1, WORD=2.
REQ-010 in_signed_i  input  1  sign-extend load result.
REQ-011 dmem_req_valid_o / dmem_req_ready_i  output / input  1 / 1  bus request handshake.
REQ-012 dmem_req_addr_o  output  32  word-aligned address ({addr[31:2],2'b00}).
REQ-013 dmem_req_we_o  output  1; dmem_req_wstrb_o  output  4; dmem_req_wdata_o  output  32.
REQ-014 dmem_resp_valid_i  input  1; dmem_resp_rdata_i  input  32  load response.
REQ-015 out_valid_o  output  1  one-cycle completion pulse to WB register.
REQ-016 out_rdata_o  output  32  extended load data (0 for stores/faults).
REQ-017 out_misaligned_o  output  1  access faulted on alignment.

Function
REQ-018 FSM states IDLE, REQ, WAIT_RESP, DONE; in_ready_o = 1 only in IDLE.
REQ-019 IDLE: on in_valid_i=1, latch addr/wdata/wr/size/signed; aligned -> REQ, misaligned -> DONE with fault flag set.
REQ-020 Misaligned: HALF with addr[0]=1, WORD with addr[1:0]!=0; no bus request issued; size=3 treated as WORD.
REQ-021 REQ: dmem_req_valid_o=1; addr/we/wstrb/wdata held constant until dmem_req_ready_i=1.
REQ-022 REQ handshake: store -> DONE; load -> WAIT_RESP.
REQ-023 wstrb: BYTE 4'b0001<<addr[1:0]; HALF 4'b0011<<addr[1:0]; WORD 4'b1111; loads drive wstrb=0, we=0.
REQ-024 wdata lane replication: BYTE {4{wdata[7:0]}}, HALF {2{wdata[15:0]}}, WORD wdata.
REQ-025 WAIT_RESP: on dmem_resp_valid_i=1 register extracted data, -> DONE; otherwise stay (no timeout).
REQ-026 Extraction: BYTE lane = rdata[8*addr[1:0]+:8], HALF lane = rdata[16*addr[1]+:16]; zero- or sign-extend per latched signed; WORD unchanged.
REQ-027 DONE: out_valid_o=1 for exactly one cycle, out_rdata_o/out_misaligned_o valid that cycle; -> IDLE.
REQ-028 out_rdata_o and out_misaligned_o retain last values outside DONE; meaningful only with out_valid_o.
REQ-029 dmem_resp_valid_i outside WAIT_RESP ignored; dmem_req_ready_i outside REQ ignored.
REQ-030 Latency from accept edge T: store with ready=1 -> out_valid at T+2; load with ready=1 and resp in WAIT_RESP's first cycle -> out_valid at T+3; misaligned -> T+1.
REQ-031 No back-to-back overlap: next request accepted earliest in IDLE cycle after DONE.

Reset
REQ-032 reset_i=1 at edge: state=IDLE, dmem_req_valid_o=0, out_valid_o=0, out_rdata_o=0, out_misaligned_o=0, latched fields=0, regardless of current state.
REQ-033 Reset mid-REQ or mid-WAIT_RESP abandons the access; late response after reset is ignored (REQ-029).
REQ-034 in_ready_o=1 in the first cycle after reset deasserts.

Verification
REQ-035 LB signed addr=0x103, rdata=0x80FF_1234, ready=1, resp 1 cycle later -> req_addr=0x100, out_rdata=0xFFFF_FF80, out_valid at T+3.
REQ-036 SH addr=0x202, wdata=0x0000_ABCD, ready low 3 cycles -> req fields stable 4 cycles, wstrb=4'b1100, wdata=0xABCD_ABCD, out_valid 1 cycle after handshake.
REQ-037 LW addr=0x301 -> dmem_req_valid_o never asserted, out_valid at T+1 with out_misaligned_o=1, out_rdata=0.
REQ-038 LHU addr=0x402, rdata=0x9876_0000 -> out_rdata=0x0000_9876; LH same -> 0xFFFF_9876.
REQ-039 reset_i pulsed in WAIT_RESP, resp arrives next cycle -> no out_valid, state IDLE, in_ready_o=1.
